// File: rtl/app_rx_pkg.sv
// Shared types for the application-stream receiver.
// State and output-kind encodings, plus the task tag value.
package app_rx_pkg;

  localparam int FLIT_SIZE_DEF = 32;

  localparam logic [FLIT_SIZE_DEF-1:0] TASK_TAG = '1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TCNT,
    ST_MAP,
    ST_TAG,
    ST_GRAPH,
    ST_TXT,
    ST_DAT,
    ST_BSS,
    ST_ENTRY,
    ST_BIN,
    ST_FATAL
  } state_e;

  typedef enum logic [1:0] {
    KIND_MAP   = 2'd0,
    KIND_GRAPH = 2'd1,
    KIND_THDR  = 2'd2,
    KIND_BIN   = 2'd3
  } kind_e;

endpackage

// File: rtl/app_rx_out_reg.sv
// One-entry valid/ready output register.
// space is high when a new flit may be loaded this cycle.
module app_rx_out_reg
  import app_rx_pkg::*;
#(
  parameter int FLIT_SIZE = 32,
  parameter int TW        = 5,
  parameter int IDX_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 ready,
  input  kind_e                ld_kind,
  input  logic [TW-1:0]        ld_task,
  input  logic [IDX_W-1:0]     ld_index,
  input  logic [FLIT_SIZE-1:0] ld_data,
  output logic                 valid,
  output logic                 space,
  output kind_e                kind,
  output logic [TW-1:0]        task_idx,
  output logic [IDX_W-1:0]     index,
  output logic [FLIT_SIZE-1:0] data
);

  assign space = !valid || ready;

  // Load replaces contents; ready without load empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      kind     <= KIND_MAP;
      task_idx <= '0;
      index    <= '0;
      data     <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      kind     <= ld_kind;
      task_idx <= ld_task;
      index    <= ld_index;
      data     <= ld_data;
    end else if (ready) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/app_stream_receiver.sv
// Receiver for the application-injection flit stream.
// Parses descriptor/task/binary flits and forwards payload.
module app_stream_receiver
  import app_rx_pkg::*;
#(
  parameter int FLIT_SIZE = 32,
  parameter int MAX_TASKS = 32,
  parameter int IDX_W     = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rx_i,
  output logic                         credit_o,
  input  logic [FLIT_SIZE-1:0]         data_i,
  input  logic                         eoa_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [1:0]                   out_kind_o,
  output logic [$clog2(MAX_TASKS)-1:0] out_task_o,
  output logic [IDX_W-1:0]             out_index_o,
  output logic [FLIT_SIZE-1:0]         out_data_o,
  output logic [FLIT_SIZE-1:0]         descr_size_o,
  output logic [FLIT_SIZE-1:0]         task_cnt_o,
  output logic                         app_start_o,
  output logic                         app_done_o,
  output logic                         tag_err_o,
  output logic                         fatal_o,
  output logic                         all_done_o
);

  localparam int TW = $clog2(MAX_TASKS);
  localparam logic [FLIT_SIZE-1:0] ONE = FLIT_SIZE'(1);

  state_e               state_q, state_d;
  logic [TW-1:0]        task_q;
  logic [FLIT_SIZE-1:0] cnt_q, txt_q, words_q, descr_q, tcnt_q;
  logic [FLIT_SIZE:0]   sum;
  logic                 space, acc, fwd;
  logic                 last_task, graph_last, bin_last, bad_cnt;
  kind_e                fkind, out_kind;
  logic [TW-1:0]        ftask;
  logic [IDX_W-1:0]     fidx;

  assign acc        = rx_i && credit_o;
  assign credit_o   = rst_ni && (state_q != ST_FATAL) && space;
  assign last_task  = FLIT_SIZE'(task_q) == tcnt_q - ONE;
  assign graph_last = cnt_q == descr_q - ONE;
  assign bin_last   = cnt_q == words_q - ONE;
  assign bad_cnt    = (data_i == '0) ||
                      (data_i > FLIT_SIZE'(MAX_TASKS));
  assign sum        = {1'b0, txt_q} + {1'b0, data_i};

  assign out_kind_o   = out_kind;
  assign descr_size_o = descr_q;
  assign task_cnt_o   = tcnt_q;
  assign all_done_o   = rst_ni && eoa_i &&
                        (state_q == ST_IDLE) && !out_valid_o;

  // Next state and forwarded-flit fields for the current state.
  always_comb begin
    state_d = state_q;
    fwd     = 1'b0;
    fkind   = KIND_THDR;
    ftask   = task_q;
    fidx    = '0;
    unique case (state_q)
      ST_IDLE:  state_d = ST_TCNT;
      ST_TCNT:  state_d = bad_cnt ? ST_FATAL : ST_MAP;
      ST_MAP: begin
        fwd     = 1'b1;
        fkind   = KIND_MAP;
        fidx    = IDX_W'(task_q);
        state_d = ST_TAG;
      end
      ST_TAG: begin
        if (!last_task)          state_d = ST_MAP;
        else if (descr_q == '0)  state_d = ST_TXT;
        else                     state_d = ST_GRAPH;
      end
      ST_GRAPH: begin
        fwd   = 1'b1;
        fkind = KIND_GRAPH;
        ftask = '0;
        fidx  = cnt_q[IDX_W-1:0];
        if (graph_last) state_d = ST_TXT;
      end
      ST_TXT: begin
        fwd     = 1'b1;
        state_d = ST_DAT;
      end
      ST_DAT: begin
        fwd     = 1'b1;
        fidx    = IDX_W'(1);
        state_d = ST_BSS;
      end
      ST_BSS: begin
        fwd     = 1'b1;
        fidx    = IDX_W'(2);
        state_d = ST_ENTRY;
      end
      ST_ENTRY: begin
        fwd  = 1'b1;
        fidx = IDX_W'(3);
        if (words_q != '0)  state_d = ST_BIN;
        else if (last_task) state_d = ST_IDLE;
        else                state_d = ST_TXT;
      end
      ST_BIN: begin
        fwd   = 1'b1;
        fkind = KIND_BIN;
        fidx  = cnt_q[IDX_W-1:0];
        if (bin_last) state_d = last_task ? ST_IDLE : ST_TXT;
      end
      ST_FATAL: state_d = ST_FATAL;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State advances only on accepted flits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  state_q <= ST_IDLE;
    else if (acc) state_q <= state_d;
  end

  // Counters, latched fields, pulses and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      task_q      <= '0;
      cnt_q       <= '0;
      txt_q       <= '0;
      words_q     <= '0;
      descr_q     <= '0;
      tcnt_q      <= '0;
      app_start_o <= 1'b0;
      app_done_o  <= 1'b0;
      tag_err_o   <= 1'b0;
      fatal_o     <= 1'b0;
    end else begin
      app_start_o <= 1'b0;
      app_done_o  <= 1'b0;
      if (acc) begin
        unique case (state_q)
          ST_IDLE: begin
            descr_q     <= data_i;
            app_start_o <= 1'b1;
          end
          ST_TCNT: begin
            tcnt_q <= data_i;
            task_q <= '0;
            if (bad_cnt) fatal_o <= 1'b1;
          end
          ST_TAG: begin
            if (data_i != TASK_TAG) tag_err_o <= 1'b1;
            task_q <= last_task ? '0 : task_q + 1'b1;
            cnt_q  <= '0;
          end
          ST_GRAPH: cnt_q   <= cnt_q + ONE;
          ST_TXT:   txt_q   <= data_i;
          ST_DAT:   words_q <= FLIT_SIZE'(sum >> 2);
          ST_ENTRY: begin
            cnt_q <= '0;
            if (words_q == '0) begin
              if (last_task) app_done_o <= 1'b1;
              else           task_q     <= task_q + 1'b1;
            end
          end
          ST_BIN: begin
            cnt_q <= cnt_q + ONE;
            if (bin_last) begin
              if (last_task) app_done_o <= 1'b1;
              else           task_q     <= task_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  app_rx_out_reg #(
    .FLIT_SIZE (FLIT_SIZE),
    .TW        (TW),
    .IDX_W     (IDX_W)
  ) u_out (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .load     (acc && fwd),
    .ready    (out_ready_i),
    .ld_kind  (fkind),
    .ld_task  (ftask),
    .ld_index (fidx),
    .ld_data  (data_i),
    .valid    (out_valid_o),
    .space    (space),
    .kind     (out_kind),
    .task_idx (out_task_o),
    .index    (out_index_o),
    .data     (out_data_o)
  );

endmodule
